// File: rtl/cex_pkg.sv
// Shared condition codes and FSM state encoding for the conditional-execution window controller.
package cex_pkg;

  localparam logic [3:0] CEX_EQ   = 4'd0;
  localparam logic [3:0] CEX_NE   = 4'd1;
  localparam logic [3:0] CEX_CS   = 4'd2;
  localparam logic [3:0] CEX_CC   = 4'd3;
  localparam logic [3:0] CEX_MI   = 4'd4;
  localparam logic [3:0] CEX_PL   = 4'd5;
  localparam logic [3:0] CEX_VS   = 4'd6;
  localparam logic [3:0] CEX_VC   = 4'd7;
  localparam logic [3:0] CEX_HI   = 4'd8;
  localparam logic [3:0] CEX_LS   = 4'd9;
  localparam logic [3:0] CEX_GE   = 4'd10;
  localparam logic [3:0] CEX_LT   = 4'd11;
  localparam logic [3:0] CEX_GT   = 4'd12;
  localparam logic [3:0] CEX_LE   = 4'd13;
  localparam logic [3:0] CEX_AL   = 4'd14;
  localparam logic [3:0] CEX_RSVD = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TBLK = 2'd1,
    FBLK = 2'd2
  } cex_state_e;

endpackage

// File: rtl/cex_cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit CEX code and the PSW flags to a pass/fail bit.
module cex_cond_eval
  import cex_pkg::*;
#(
  parameter int PSW_W = 16,
  parameter int C_BIT = 0,
  parameter int Z_BIT = 1,
  parameter int N_BIT = 2,
  parameter int V_BIT = 4
) (
  input  logic [3:0]       code,
  input  logic [PSW_W-1:0] psw,
  output logic             result
);

  logic w_c, w_z, w_n, w_v;
  logic w_unused_psw;

  assign w_c = psw[C_BIT];
  assign w_z = psw[Z_BIT];
  assign w_n = psw[N_BIT];
  assign w_v = psw[V_BIT];
  // Only four PSW bits matter; the reduction keeps the rest of the bus visibly consumed.
  assign w_unused_psw = ^psw;

  always_comb begin
    result = 1'b0;
    case (code)
      CEX_EQ:  result = w_z;
      CEX_NE:  result = ~w_z;
      CEX_CS:  result = w_c;
      CEX_CC:  result = ~w_c;
      CEX_MI:  result = w_n;
      CEX_PL:  result = ~w_n;
      CEX_VS:  result = w_v;
      CEX_VC:  result = ~w_v;
      CEX_HI:  result = w_c & ~w_z;
      CEX_LS:  result = ~w_c | w_z;
      CEX_GE:  result = (w_n == w_v);
      CEX_LT:  result = (w_n != w_v);
      CEX_GT:  result = ~w_z & (w_n == w_v);
      CEX_LE:  result = w_z | (w_n != w_v);
      CEX_AL:  result = 1'b1;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cex_window_ctrl.sv
// Conditional-execution window controller: latches a CEX condition and gates execute for the
// following True block (T instrs) and False block (F instrs).
//   state | meaning
//   IDLE  | no window open, every instruction executes
//   TBLK  | True block, execute iff cond_q
//   FBLK  | False block, execute iff ~cond_q
module cex_window_ctrl
  import cex_pkg::*;
#(
  parameter int PSW_W = 16,
  parameter int CNT_W = 3,
  parameter int C_BIT = 0,
  parameter int Z_BIT = 1,
  parameter int N_BIT = 2,
  parameter int V_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cex_valid,
  input  logic [3:0]       cex_code,
  input  logic [CNT_W-1:0] cex_tcnt,
  input  logic [CNT_W-1:0] cex_fcnt,
  input  logic [PSW_W-1:0] psw_in,
  input  logic             instr_retire,
  input  logic             flush,
  output logic             exec_en,
  output logic             cex_active,
  output logic             cond_q,
  output logic [CNT_W-1:0] remain,
  output logic             cex_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cex_state_e       r_state;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_cond;
  logic             r_exec_en;
  logic             r_active;
  logic             r_err;

  cex_state_e       w_nstate;
  logic [CNT_W-1:0] w_nremain;
  logic [CNT_W-1:0] w_nfcnt;
  logic             w_ncond;
  logic             w_nexec;
  logic             w_nerr;
  logic             w_cond;
  logic             w_accept;

  cex_cond_eval #(
    .PSW_W (PSW_W),
    .C_BIT (C_BIT),
    .Z_BIT (Z_BIT),
    .N_BIT (N_BIT),
    .V_BIT (V_BIT)
  ) u_eval (
    .code   (cex_code),
    .psw    (psw_in),
    .result (w_cond)
  );

  // A CEX inside a squashed slot is itself a NOP and must not disturb the window.
  assign w_accept = cex_valid && ((r_state == IDLE) || r_exec_en);

  always_comb begin
    w_nstate  = r_state;
    w_nremain = r_remain;
    w_nfcnt   = r_fcnt;
    w_ncond   = r_cond;
    w_nerr    = 1'b0;
    if (flush) begin
      w_nstate  = IDLE;
      w_nremain = CNT_ZERO;
    end else if (w_accept) begin
      w_ncond = w_cond;
      w_nfcnt = cex_fcnt;
      w_nerr  = (cex_code == CEX_RSVD);
      if (cex_tcnt != CNT_ZERO) begin
        w_nstate  = TBLK;
        w_nremain = cex_tcnt;
      end else if (cex_fcnt != CNT_ZERO) begin
        w_nstate  = FBLK;
        w_nremain = cex_fcnt;
      end else begin
        w_nstate  = IDLE;
        w_nremain = CNT_ZERO;
      end
    end else if (instr_retire) begin
      case (r_state)
        TBLK: begin
          if (r_remain <= CNT_ONE) begin
            if (r_fcnt != CNT_ZERO) begin
              w_nstate  = FBLK;
              w_nremain = r_fcnt;
            end else begin
              w_nstate  = IDLE;
              w_nremain = CNT_ZERO;
            end
          end else begin
            w_nremain = r_remain - CNT_ONE;
          end
        end
        FBLK: begin
          if (r_remain <= CNT_ONE) begin
            w_nstate  = IDLE;
            w_nremain = CNT_ZERO;
          end else begin
            w_nremain = r_remain - CNT_ONE;
          end
        end
        default: ;
      endcase
    end

    case (w_nstate)
      TBLK:    w_nexec = w_ncond;
      FBLK:    w_nexec = ~w_ncond;
      default: w_nexec = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_remain  <= CNT_ZERO;
      r_fcnt    <= CNT_ZERO;
      r_cond    <= 1'b0;
      r_exec_en <= 1'b1;
      r_active  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_remain  <= w_nremain;
      r_fcnt    <= w_nfcnt;
      r_cond    <= w_ncond;
      r_exec_en <= w_nexec;
      r_active  <= (w_nstate != IDLE);
      r_err     <= w_nerr;
    end
  end

  assign exec_en    = r_exec_en;
  assign cex_active = r_active;
  assign cond_q     = r_cond;
  assign remain     = r_remain;
  assign cex_err    = r_err;

endmodule

// File: tb/tb_cex_window_ctrl.sv
// Self-checking bench for cex_window_ctrl: vector table plus scoreboard queue, with hand sequences
// for code sweep and asynchronous reset.
module tb_cex_window_ctrl;

  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic [2:0]  t;
    logic [2:0]  f;
    logic [15:0] psw;
    logic        ret;
    logic        fl;
    logic        e_exec;
    logic        e_act;
    logic        e_cond;
    logic [2:0]  e_rem;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        exec_en;
    logic        act;
    logic        cond;
    logic [2:0]  rem;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cex_valid;
  logic [3:0]  cex_code;
  logic [2:0]  cex_tcnt;
  logic [2:0]  cex_fcnt;
  logic [15:0] psw_in;
  logic        instr_retire;
  logic        flush;
  logic        exec_en;
  logic        cex_active;
  logic        cond_q;
  logic [2:0]  remain;
  logic        cex_err;

  int   n_pass;
  int   n_total;
  vec_t vecs[$];
  exp_t sb[$];

  cex_window_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cex_valid    (cex_valid),
    .cex_code     (cex_code),
    .cex_tcnt     (cex_tcnt),
    .cex_fcnt     (cex_fcnt),
    .psw_in       (psw_in),
    .instr_retire (instr_retire),
    .flush        (flush),
    .exec_en      (exec_en),
    .cex_active   (cex_active),
    .cond_q       (cond_q),
    .remain       (remain),
    .cex_err      (cex_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [3:0] code, logic [2:0] t, logic [2:0] f,
                              logic [15:0] psw, logic ret, logic fl, logic ee, logic ea,
                              logic ec, logic [2:0] er, logic eerr);
    vec_t x;
    x.v = v; x.code = code; x.t = t; x.f = f; x.psw = psw; x.ret = ret; x.fl = fl;
    x.e_exec = ee; x.e_act = ea; x.e_cond = ec; x.e_rem = er; x.e_err = eerr;
    return x;
  endfunction

  // Reference condition evaluation: C=bit0, Z=bit1, N=bit2, V=bit4.
  function automatic logic ref_eval(logic [3:0] code, logic [15:0] psw);
    logic c, z, n, v;
    c = psw[0]; z = psw[1]; n = psw[2]; v = psw[4];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_exp(logic ee, logic ea, logic ec, logic [2:0] er, logic eerr, string nm);
    exp_t e;
    e.exec_en = ee; e.act = ea; e.cond = ec; e.rem = er; e.err = eerr; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [6:0] got, want;
    e = sb.pop_front();
    got  = {exec_en, cex_active, cond_q, remain, cex_err};
    want = {e.exec_en, e.act, e.cond, e.rem, e.err};
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got exec=%b act=%b cond=%b rem=%0d err=%b, want exec=%b act=%b cond=%b rem=%0d err=%b",
                  e.name, exec_en, cex_active, cond_q, remain, cex_err,
                  e.exec_en, e.act, e.cond, e.rem, e.err);
  endtask

  task automatic step(vec_t x, string nm);
    @(negedge clk);
    cex_valid    = x.v;
    cex_code     = x.code;
    cex_tcnt     = x.t;
    cex_fcnt     = x.f;
    psw_in       = x.psw;
    instr_retire = x.ret;
    flush        = x.fl;
    push_exp(x.e_exec, x.e_act, x.e_cond, x.e_rem, x.e_err, nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    cex_valid = 1'b0; cex_code = 4'd0; cex_tcnt = 3'd0; cex_fcnt = 3'd0;
    psw_in = 16'h0; instr_retire = 1'b0; flush = 1'b0;

    //                v  code   t     f     psw       ret fl   exec act cond rem err
    vecs.push_back(mk(1, 4'd0,  3'd2, 3'd1, 16'h0002, 0, 0,  1, 1, 1, 3'd2, 0)); // EQ taken
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  0, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 1, 3'd0, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 1, 3'd0, 0)); // retire in IDLE
    vecs.push_back(mk(1, 4'd0,  3'd2, 3'd1, 16'h0000, 0, 0,  0, 1, 0, 3'd2, 0)); // EQ not taken
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(1, 4'd10, 3'd0, 3'd2, 16'h0004, 0, 0,  1, 1, 0, 3'd2, 0)); // GE, T=0
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(1, 4'd8,  3'd3, 3'd3, 16'h0001, 0, 0,  1, 1, 1, 3'd3, 0)); // HI then flush
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 0, 1,  1, 0, 1, 3'd0, 0));
    vecs.push_back(mk(1, 4'd15, 3'd1, 3'd1, 16'hFFFF, 0, 0,  0, 1, 0, 3'd1, 1)); // reserved code
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 0, 0,  0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(1, 4'd0,  3'd3, 3'd2, 16'h0002, 0, 0,  1, 1, 1, 3'd3, 0)); // restart cases
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 1, 3'd2, 0));
    vecs.push_back(mk(1, 4'd1,  3'd2, 3'd1, 16'h0002, 0, 0,  0, 1, 0, 3'd2, 0));
    vecs.push_back(mk(1, 4'd14, 3'd1, 3'd1, 16'h0000, 0, 0,  0, 1, 0, 3'd2, 0)); // squashed CEX
    vecs.push_back(mk(1, 4'd15, 3'd1, 3'd1, 16'h0000, 0, 0,  0, 1, 0, 3'd2, 0)); // squashed, no err
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 0, 3'd1, 0));
    vecs.push_back(mk(1, 4'd14, 3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 1, 3'd0, 0)); // T=F=0, retire ignored
    vecs.push_back(mk(1, 4'd0,  3'd1, 3'd1, 16'h0000, 0, 1,  1, 0, 1, 3'd0, 0)); // flush beats cex
    vecs.push_back(mk(1, 4'd14, 3'd7, 3'd7, 16'h0000, 0, 0,  1, 1, 1, 3'd7, 0)); // max count
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 1, 1, 3'd6, 0));
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 0, 1,  1, 0, 1, 3'd0, 0));
    vecs.push_back(mk(1, 4'd2,  3'd1, 3'd0, 16'h0001, 0, 0,  1, 1, 1, 3'd1, 0)); // F=0 exit
    vecs.push_back(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0,  1, 0, 1, 3'd0, 0));

    #12;
    push_exp(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "reset_held");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "after_reset");
    check_out();

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Sweep every code from IDLE with random flags; T=F=0 keeps the window closed.
    for (int c = 0; c < 16; c++) begin
      logic [15:0] p;
      logic [3:0]  cc;
      p  = 16'($urandom_range(0, 31));
      cc = 4'(c);
      step(mk(1'b1, cc, 3'd0, 3'd0, p, 1'b0, 1'b0, 1'b1, 1'b0, ref_eval(cc, p), 3'd0, cc == 4'd15),
           $sformatf("code%0d_psw%h", c, p));
    end

    // Asynchronous reset in the middle of a True block.
    step(mk(1, 4'd14, 3'd5, 3'd2, 16'h0000, 0, 0, 1, 1, 1, 3'd5, 0), "async_pre");
    step(mk(0, 4'd0,  3'd0, 3'd0, 16'h0000, 1, 0, 1, 1, 1, 3'd4, 0), "async_pre2");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "async_reset");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 4'd0, 3'd0, 3'd0, 16'h0000, 1, 0, 1, 0, 0, 3'd0, 0), "post_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
